// File: rtl/bp_nonsynth_pkg.sv
// Shared types for the nonsynthesizable commit scheduler.
// Holds the scheduler state encoding and a core-index width helper.
package bp_nonsynth_pkg;

    typedef enum logic [1:0] {
        e_run   = 2'd0,
        e_drain = 2'd1,
        e_done  = 2'd2,
        e_hang  = 2'd3
    } bp_nonsynth_sched_state_e;

    // A single core still needs a 1-bit index port.
    function automatic int core_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_nonsynth_rr_arb.sv
// One-hot round-robin arbiter: lowest request at or above ptr_i wins, else lowest overall.
// Purely combinational; no backpressure of its own.
module bp_nonsynth_rr_arb
    import bp_nonsynth_pkg::*;
#(
    parameter int num_req_p = 4
) (
    input  logic [num_req_p-1:0]                 req_i,
    input  logic [core_idx_width(num_req_p)-1:0] ptr_i,
    output logic [num_req_p-1:0]                 grant_o,
    output logic [core_idx_width(num_req_p)-1:0] idx_o,
    output logic                                 v_o
);

    localparam int idx_width_lp = core_idx_width(num_req_p);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        v_o     = 1'b0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!v_o && req_i[k] && (k >= int'(ptr_i))) begin
                v_o        = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = idx_width_lp'(k);
            end
        end
        // Nothing at or above the pointer: wrap to the lowest requester.
        for (int k = 0; k < num_req_p; k++) begin
            if (!v_o && req_i[k]) begin
                v_o        = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = idx_width_lp'(k);
            end
        end
    end

endmodule

// File: rtl/bp_nonsynth_commit_scheduler.sv
// Round-robin serializer of per-core commits onto one registered checker step port; accept-to-step 1 cycle.
// A held step blocks new grants until yumi; capped cores (and all cores once done) are accepted and dropped.
module bp_nonsynth_commit_scheduler
    import bp_nonsynth_pkg::*;
#(
    parameter int num_core_p     = 4,
    parameter int commit_width_p = 128,
    parameter int cnt_width_p    = 32,
    parameter int watchdog_p     = 65536
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [num_core_p-1:0]                 commit_v_i,
    input  logic [num_core_p*commit_width_p-1:0]  commit_data_i,
    output logic [num_core_p-1:0]                 commit_ready_and_o,
    input  logic [cnt_width_p-1:0]                instr_cap_i,
    output logic                                  step_v_o,
    output logic [core_idx_width(num_core_p)-1:0] step_core_o,
    output logic [commit_width_p-1:0]             step_data_o,
    input  logic                                  step_yumi_i,
    output logic [num_core_p*cnt_width_p-1:0]     count_o,
    output logic                                  done_o,
    output logic                                  timeout_o
);

    localparam int idx_width_lp = core_idx_width(num_core_p);
    localparam int wd_width_lp  = $clog2(watchdog_p + 1);
    localparam logic [wd_width_lp-1:0] wd_max_lp = wd_width_lp'(watchdog_p);

    bp_nonsynth_sched_state_e state_q, state_n;
    logic [cnt_width_p-1:0]  cnt_q [num_core_p];
    logic [idx_width_lp-1:0] ptr_q, ptr_n;
    logic [wd_width_lp-1:0]  wd_q, wd_n;
    logic [num_core_p-1:0]   capped, arb_grant;
    logic [idx_width_lp-1:0] arb_idx;
    logic [commit_width_p-1:0] step_data_n;
    logic arb_v, cap_nz, all_capped, stage_free, arb_en, grant;

    // Capped compares with >= so lowering the cap below a count applies at once.
    always_comb begin
        capped = '0;
        for (int k = 0; k < num_core_p; k++) begin
            capped[k] = cap_nz && (cnt_q[k] >= instr_cap_i);
        end
    end

    assign cap_nz     = (instr_cap_i != '0);
    assign all_capped = cap_nz && (&capped);
    assign stage_free = !step_v_o || step_yumi_i;
    assign arb_en     = stage_free && ((state_q == e_run) || (state_q == e_hang));
    assign grant      = arb_en && arb_v;
    assign ptr_n      = (arb_idx == idx_width_lp'(num_core_p - 1)) ? '0 : arb_idx + idx_width_lp'(1);

    bp_nonsynth_rr_arb #(.num_req_p(num_core_p)) arb (
        .req_i   (commit_v_i & ~capped),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .v_o     (arb_v)
    );

    always_comb begin
        commit_ready_and_o = '0;
        if (reset_i) begin
            if (state_q == e_done) commit_ready_and_o = commit_v_i;
            else commit_ready_and_o = (grant ? arb_grant : '0) | (commit_v_i & capped);
        end
    end

    always_comb begin
        step_data_n = '0;
        for (int k = 0; k < num_core_p; k++) begin
            if (arb_grant[k]) step_data_n = commit_data_i[k*commit_width_p +: commit_width_p];
        end
    end

    always_comb begin
        wd_n = wd_q;
        if (grant || step_yumi_i) wd_n = '0;
        else if ((state_q == e_run) && !(&capped) && (wd_q != wd_max_lp)) wd_n = wd_q + wd_width_lp'(1);
    end

    always_comb begin
        state_n   = state_q;
        done_o    = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            e_run: begin
                // Nothing can be granted once all are capped, so a free stage is empty next cycle.
                if (all_capped) state_n = stage_free ? e_done : e_drain;
                else if (wd_n == wd_max_lp) state_n = e_hang;
            end
            e_drain: if (stage_free) state_n = e_done;
            e_done:  done_o = 1'b1;
            e_hang:  timeout_o = 1'b1;
            default: state_n = e_run;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= e_run;
            ptr_q       <= '0;
            wd_q        <= '0;
            step_v_o    <= 1'b0;
            step_core_o <= '0;
            step_data_o <= '0;
            for (int k = 0; k < num_core_p; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_n;
            wd_q    <= wd_n;
            if (grant) begin
                step_v_o    <= 1'b1;
                step_core_o <= arb_idx;
                step_data_o <= step_data_n;
                ptr_q       <= ptr_n;
            end else if (step_yumi_i) begin
                step_v_o <= 1'b0;
            end
            for (int k = 0; k < num_core_p; k++) begin
                if (grant && arb_grant[k] && !(&cnt_q[k])) cnt_q[k] <= cnt_q[k] + cnt_width_p'(1);
            end
        end
    end

    for (genvar k = 0; k < num_core_p; k++) begin : g_count
        assign count_o[k*cnt_width_p +: cnt_width_p] = cnt_q[k];
    end

endmodule

// File: tb/tb_bp_nonsynth_commit_scheduler.sv
// Bench for bp_nonsynth_commit_scheduler: three cores, narrow payload/counters, 16-cycle watchdog.
// A behavioural model is compared on every falling edge; directed cases pin literal values.
module tb_bp_nonsynth_commit_scheduler;

    localparam int N = 3, W = 16, CW = 8, WD = 16;
    localparam int RUN = 0, DRAIN = 1, DONE = 2, HANG = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]   v, rdy;
    logic [N*W-1:0] data;
    logic [CW-1:0]  cap;
    logic           step_v, yumi, done, timeout;
    logic [1:0]     step_core;
    logic [W-1:0]   step_data;
    logic [N*CW-1:0] count;

    int n_chk = 0;
    int n_fail = 0;

    int m_mode, m_ptr, m_wd, m_core;
    int m_cnt [N];
    bit m_v;
    logic [W-1:0] m_data;

    always #5 clk = ~clk;

    bp_nonsynth_commit_scheduler #(
        .num_core_p(N), .commit_width_p(W), .cnt_width_p(CW), .watchdog_p(WD)
    ) dut (
        .clk_i(clk), .reset_i(rst_n), .commit_v_i(v), .commit_data_i(data),
        .commit_ready_and_o(rdy), .instr_cap_i(cap), .step_v_o(step_v),
        .step_core_o(step_core), .step_data_o(step_data), .step_yumi_i(yumi),
        .count_o(count), .done_o(done), .timeout_o(timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = RUN; m_ptr = 0; m_wd = 0; m_core = 0; m_v = 1'b0; m_data = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] capd, exp_rdy;
        logic [N*CW-1:0] exp_cnt;
        int g, c;
        bit freev, allcap, anyunc;
        if (!rst_n) begin
            model_reset();
            chk("rst_ready", rdy, 0);
            chk("rst_step_v", step_v, 0);
            chk("rst_step_core", step_core, 0);
            chk("rst_step_data", step_data, 0);
            chk("rst_count", count, 0);
            chk("rst_done", done, 0);
            chk("rst_timeout", timeout, 0);
        end else begin
            freev = !m_v || yumi;
            allcap = (cap != 0);
            anyunc = 1'b0;
            for (int i = 0; i < N; i++) begin
                capd[i] = (cap != 0) && (m_cnt[i] >= int'(cap));
                allcap = allcap && capd[i];
                anyunc = anyunc || !capd[i];
                exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
            end
            g = -1;
            if ((m_mode == RUN || m_mode == HANG) && freev) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (g < 0 && v[c] && !capd[c]) g = c;
                end
            end
            for (int i = 0; i < N; i++)
                exp_rdy[i] = (m_mode == DONE) ? v[i] : ((g == i) || (v[i] && capd[i]));
            chk("ready", rdy, exp_rdy);
            chk("step_v", step_v, m_v);
            chk("step_core", step_core, m_core);
            chk("step_data", step_data, m_data);
            chk("count", count, exp_cnt);
            chk("done", done, m_mode == DONE);
            chk("timeout", timeout, m_mode == HANG);
            // Advance the model across the coming rising edge.
            if (g >= 0) begin
                m_v = 1'b1; m_core = g; m_data = data[g*W +: W];
                if (m_cnt[g] < (1 << CW) - 1) m_cnt[g]++;
                m_ptr = (g + 1) % N;
            end else if (yumi) begin
                m_v = 1'b0;
            end
            if (g >= 0 || yumi) m_wd = 0;
            else if (m_mode == RUN && anyunc && m_wd < WD) m_wd++;
            if (m_mode == RUN) begin
                if (allcap) m_mode = DRAIN;
                else if (m_wd == WD) m_mode = HANG;
            end
            if (m_mode == DRAIN && !m_v) m_mode = DONE;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
    endtask

    task automatic do_reset(input logic [CW-1:0] c, input logic [N-1:0] v0);
        cyc();
        rst_n = 1'b0; v = '0; yumi = 1'b0;
        cyc();
        cap = c; rst_n = 1'b1; v = v0;
    endtask

    initial begin
        rst_n = 1'b0; v = '0; data = '0; cap = '0; yumi = 1'b0;
        repeat (2) @(posedge clk);
        #1 v = '1;
        @(negedge clk);
        chk("reset_ready_lit", rdy, 3'b000);
        chk("reset_step_v_lit", step_v, 0);
        chk("reset_count_lit", count, 0);

        // Watchdog: 16 idle edges after release declare a hang; forwarding continues.
        v = '0;
        cyc();
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk); chk("wd_15_edges", timeout, 0);
        @(posedge clk);
        @(negedge clk); chk("wd_16_edges", timeout, 1);
        cyc(); v = 3'b010; rand_data();
        cyc(); v = '0; yumi = step_v;
        @(negedge clk); chk("hang_fwd_v", step_v, 1); chk("hang_fwd_core", step_core, 1);
        cyc(); yumi = 1'b0;

        // Round robin with everything valid.
        do_reset(0, '1);
        for (int i = 0; i < 6; i++) begin
            cyc(); yumi = step_v; rand_data();
            @(negedge clk); chk("rr_core", step_core, i % 3); chk("rr_v", step_v, 1);
        end
        chk("rr_counts", count, 24'h020202);

        // Held step under backpressure, then the pointer continues past the holder.
        cyc(); v = '0; yumi = step_v;
        cyc(); yumi = 1'b0; v = 3'b110;
        for (int i = 0; i < 5; i++) begin
            cyc(); yumi = 1'b0;
            @(negedge clk); chk("stall_core", step_core, 1); chk("stall_ready", rdy, 3'b000);
        end
        cyc(); yumi = 1'b1;
        @(negedge clk); chk("unstall_ready", rdy, 3'b100);
        cyc(); v = '0; yumi = 1'b1;
        @(negedge clk); chk("unstall_core", step_core, 2);
        cyc(); yumi = 1'b0; v = 3'b010;

        // Pointer at 2 with only core 0 valid wraps to core 0, pointer then 1.
        cyc(); v = 3'b001; yumi = step_v;
        @(negedge clk); chk("ptr2_ready", rdy, 3'b001);
        cyc(); v = 3'b111; yumi = 1'b1;
        @(negedge clk); chk("ptr2_core", step_core, 0); chk("ptr1_ready", rdy, 3'b010);
        cyc(); v = '0; yumi = 1'b1;
        @(negedge clk); chk("ptr1_core", step_core, 1);
        cyc(); yumi = 1'b0;

        // Cap of 2: six steps, then capped cores are accepted and done follows the last yumi.
        do_reset(2, '1);
        for (int i = 0; i < 6; i++) begin
            cyc(); yumi = step_v; rand_data();
            @(negedge clk); chk("cap_core", step_core, i % 3);
        end
        chk("cap_ready_all", rdy, 3'b111);
        chk("cap_done_early", done, 0);
        cyc(); yumi = step_v;
        @(negedge clk);
        chk("cap_done", done, 1); chk("cap_done_v", step_v, 0);
        chk("cap_done_ready", rdy, 3'b111); chk("cap_counts", count, 24'h020202);

        // Lowering the cap below the counts caps every core in the same cycle.
        do_reset(0, '1);
        for (int i = 0; i < 7; i++) begin cyc(); yumi = step_v; end
        cyc(); cap = 1; yumi = step_v;
        @(negedge clk); chk("cap_lower_ready", rdy, 3'b111);
        cyc(); yumi = step_v;
        @(negedge clk); chk("cap_lower_done", done, 1);

        // Asynchronous reset from done, and again with a step held.
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk("async_done", done, 0); chk("async_count", count, 0); chk("async_ready", rdy, 0);
        cyc(); rst_n = 1'b1; cap = 0; v = '1; yumi = 1'b0;
        cyc(); yumi = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("async_step_v", step_v, 0); chk("async_core", step_core, 0); chk("async_data", step_data, 0);
        cyc(); rst_n = 1'b1;
        cyc();
        @(negedge clk); chk("resume_v", step_v, 1); chk("resume_core", step_core, 0);

        for (int seg = 0; seg < 8; seg++) begin
            int vp, yp, ncyc;
            logic [CW-1:0] c;
            if (seg == 0) begin c = 0; vp = 100; yp = 100; ncyc = 900; end
            else if (seg == 1) begin c = 0; vp = 3; yp = 60; ncyc = 300; end
            else begin
                c = (seg % 3 == 0) ? CW'(0) : CW'($urandom_range(3, 30));
                vp = $urandom_range(10, 90); yp = $urandom_range(20, 100); ncyc = 400;
            end
            do_reset(c, '0);
            repeat (ncyc) begin
                cyc();
                for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < vp);
                rand_data();
                yumi = step_v && ($urandom_range(0, 99) < yp);
                if ($urandom_range(0, 199) == 0) cap = CW'($urandom_range(0, 20));
            end
        end

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_commit_scheduler.md
# bp_nonsynth_commit_scheduler

Nonsynthesizable scheduler that serializes per-core commit streams from `num_core_p` cores onto the single shared cosimulation step port, where one checker instance steps the reference model. Arbitration is round-robin. The block counts instructions retired per core and enforces the per-run instruction cap. It also detects global hangs and reports completion. It sits between each core's commit tap and the shared checker.

## Interface
- `num_core_p`, 4, number of requesting cores; need not be a power of two.
- `commit_width_p`, 128, opaque commit payload width.
- `cnt_width_p`, 32, per-core retired counter width.
- `watchdog_p`, 65536, idle cycles before a hang is declared.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `commit_v_i`  in  num_core_p  per-core commit valid.
- `commit_data_i`  in  num_core_p*commit_width_p  per-core payload; core i occupies bits [i*commit_width_p +: commit_width_p].
- `commit_ready_and_o`  out  num_core_p  per-core accept; a transfer occurs when v&ready.
- `instr_cap_i`  in  cnt_width_p  per-core retire cap; 0 means unlimited.
- `step_v_o`  out  1  registered step valid.
- `step_core_o`  out  clog2(num_core_p) (min 1)  originating core.
- `step_data_o`  out  commit_width_p  payload.
- `step_yumi_i`  in  1  checker consumes the step; legal only when step_v_o=1.
- `count_o`  out  num_core_p*cnt_width_p  per-core forwarded-commit counts.
- `done_o`  out  1  all cores have reached the cap and the output stage is empty; sticky.
- `timeout_o`  out  1  watchdog expired; sticky.

## Operation
- The output stage holds one entry. It is free when `step_v_o=0` or `step_yumi_i=1`.
- Eligibility: core i is eligible when `commit_v_i[i]` is high and the core is not capped.
- When the output stage is free, the oldest-priority eligible core per the round-robin pointer is granted. Its `commit_ready_and_o` is high and its payload is loaded.
- The pointer moves to grant+1, wrapping from num_core_p-1 to 0. It is unchanged when there is no grant.
- Capped core: its count equals a nonzero `instr_cap_i`. Commits from a capped core are accepted (`ready_and=1`) and dropped; they are not forwarded and not counted. This prevents a capped core from stalling.
- Counts increment on each forwarded grant. When the cap is 0, counts saturate at all-ones.
- State machine (enum):
  - `e_run`: normal arbitration.
    - Go to `e_drain` when every core is capped and `instr_cap_i` is nonzero.
    - Go to `e_hang` when the watchdog reaches `watchdog_p`.
  - `e_drain`: no new grants; waits for the output stage to empty, then goes to `e_done`.
  - `e_done`: `done_o=1`. All commits are accepted and dropped.
  - `e_hang`: `timeout_o=1`. Arbitration continues so the checker can still log.
  - `e_done` and `e_hang` are left only on reset.
- Watchdog:
  - Clears on any grant or yumi.
  - Otherwise increments each cycle in `e_run` while any core is uncapped.
  - Saturates at `watchdog_p`.

## Timing
- Accept to `step_v_o` is 1 cycle. Sustained throughput is 1 step/cycle when yumi and a new grant occur in the same cycle.
- `commit_ready_and_o` is combinational from `commit_v_i`, state, pointer, and output-stage occupancy. It never depends on `commit_data_i`.
- `step_*` outputs are registered and hold stable while `step_v_o=1` and `step_yumi_i=0`.
- Reset values:
  - `step_v_o=0`, `step_core_o=0`, `step_data_o=0`.
  - Pointer 0, all counts 0, watchdog 0, state `e_run`.
  - `done_o=0`, `timeout_o=0`.
  - `commit_ready_and_o=0` while reset is asserted.
- Reset asserted mid-transfer discards the held entry immediately (asynchronous).
- A change to `instr_cap_i` below a core's current count takes effect in the same cycle; that core is treated as capped.
- `num_core_p=1`: no arbitration; the pointer stays 0.

## Structure
- `bp_nonsynth_pkg` holds `bp_nonsynth_sched_state_e` (`e_run`, `e_drain`, `e_done`, `e_hang`).
- One sub-module, `bp_nonsynth_rr_arb`: a parameterized one-hot round-robin arbiter with a pointer input. Its output is the grant vector plus an encoded index.
- Counters, watchdog, FSM, and the output register live in the top module.

## Test plan
- Single core, cap=3, five commits with yumi held high → three steps on consecutive cycles; `done_o=1` one cycle after the third yumi; the last two commits are accepted and dropped.
- Four cores all valid every cycle, yumi=1, cap=0 → `step_core_o` sequence is 0,1,2,3,0,…; each count=N/4 after N steps.
- Cores 1 and 3 valid, yumi held low for 5 cycles → `step_*` stable; `commit_ready_and_o=0000`; after yumi, the next grant goes to core 3.
- `watchdog_p=16`, no commits, cap=0 → `timeout_o` rises on cycle 16; a later commit is still forwarded.
- Three cores (non-power-of-two), pointer at 2 with core 0 valid → grant core 0; pointer becomes 1.
- Reset pulse while `step_v_o=1` → `step_v_o=0`, counts 0, `done_o=0` immediately; normal arbitration resumes after release.
